layer_seq_ctrl: RTL and testbench

Multi-layer sequencer for the 4-MAC systolic array. On one `start`, it steps through `cfg_layers` layers. For each layer it requests a weight load from the weight memory interface, streams `cfg_k` input words from the input memory with a one-cycle-aligned MAC valid strobe, waits for all MAC outputs to be valid, emits a capture pulse and clears the accumulators. It sits between the top-level controller and the weight memory, input memory and MAC array, and replaces ad-hoc start fan-out with a single handshake.

---
 rtl/seq_pkg.sv | 24 ++
 rtl/seq_addr_gen.sv | 54 +++++
 rtl/layer_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_layer_seq_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and defaults for the multi-layer MAC sequencer.
// State encoding, default widths and the weight-base stride.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        WAIT_W,
        STREAM,
        DRAIN,
        CAPTURE,
        CLEAR,
        FINISH
    } state_t;

    localparam int N_MACS_DEF   = 4;
    localparam int ADDR_W_DEF   = 8;
    localparam int LAYER_W_DEF  = 3;
    localparam int DRAIN_TO_DEF = 32;

    // Each layer owns one weight word per MAC column.
    localparam int W_STRIDE = N_MACS_DEF;

endpackage

// File: rtl/seq_addr_gen.sv
// Layer/word counters and the input and weight address arithmetic.
// All addresses are truncated to ADDR_W after a full-width multiply.
module seq_addr_gen
    import seq_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LAYER_W = LAYER_W_DEF,
    parameter int STRIDE  = W_STRIDE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               k_clr,
    input  logic               k_inc,
    input  logic               layer_inc,
    input  logic [ADDR_W-1:0]  cfg_k,
    input  logic [LAYER_W-1:0] cfg_layers,
    output logic [LAYER_W-1:0] layer_idx,
    output logic [ADDR_W-1:0]  in_addr,
    output logic [ADDR_W-1:0]  w_base,
    output logic               last_read,
    output logic               last_layer
);

    localparam int PW = LAYER_W + ADDR_W;

    logic [ADDR_W-1:0] k_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_cnt     <= '0;
            layer_idx <= '0;
        end else begin
            if (init)
                layer_idx <= '0;
            else if (layer_inc)
                layer_idx <= layer_idx + LAYER_W'(1);
            if (init || k_clr)
                k_cnt <= '0;
            else if (k_inc)
                k_cnt <= k_cnt + ADDR_W'(1);
        end
    end

    assign in_addr = ADDR_W'({{ADDR_W{1'b0}}, layer_idx}
                   * {{LAYER_W{1'b0}}, cfg_k}) + k_cnt;

    assign w_base = ADDR_W'({{ADDR_W{1'b0}}, layer_idx} * PW'(STRIDE));

    // cfg_k of zero wraps to all-ones, giving a full 2^ADDR_W read burst.
    assign last_read  = (k_cnt == cfg_k - ADDR_W'(1));
    assign last_layer = (layer_idx == cfg_layers - LAYER_W'(1));

endmodule

// File: rtl/layer_seq_ctrl.sv
// Multi-layer sequencer: per layer loads weights, streams inputs,
// drains the MAC array, captures the result and clears accumulators.
module layer_seq_ctrl
    import seq_pkg::*;
#(
    parameter int N_MACS   = N_MACS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LAYER_W  = LAYER_W_DEF,
    parameter int DRAIN_TO = DRAIN_TO_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LAYER_W-1:0] cfg_layers,
    input  logic [ADDR_W-1:0]  cfg_k,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               w_load,
    output logic [ADDR_W-1:0]  w_base,
    input  logic               w_busy,
    output logic               in_rd_en,
    output logic [ADDR_W-1:0]  in_addr,
    output logic [N_MACS-1:0]  mac_valid,
    output logic [N_MACS-1:0]  mac_clear,
    input  logic [N_MACS-1:0]  mac_valid_out,
    output logic               capture
);

    localparam int DW = $clog2(DRAIN_TO) + 1;

    state_t state, next;

    logic [LAYER_W-1:0] layers_q;
    logic [ADDR_W-1:0]  k_q;
    logic [DW-1:0]      drain_cnt;
    logic               mv_q;
    logic               accept, k_clr, k_inc, layer_inc, drain_tmo;
    logic               last_read, last_layer;

    seq_addr_gen #(
        .ADDR_W  (ADDR_W),
        .LAYER_W (LAYER_W),
        .STRIDE  (N_MACS)
    ) u_addr (
        .clk        (clk),
        .rst        (rst),
        .init       (accept),
        .k_clr      (k_clr),
        .k_inc      (k_inc),
        .layer_inc  (layer_inc),
        .cfg_k      (k_q),
        .cfg_layers (layers_q),
        .layer_idx  (layer_idx),
        .in_addr    (in_addr),
        .w_base     (w_base),
        .last_read  (last_read),
        .last_layer (last_layer)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            layers_q  <= '0;
            k_q       <= '0;
            drain_cnt <= '0;
            mv_q      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= next;
            mv_q  <= (state == STREAM);
            if (accept) begin
                layers_q <= cfg_layers;
                k_q      <= cfg_k;
            end
            if (state == DRAIN)
                drain_cnt <= drain_cnt + DW'(1);
            else
                drain_cnt <= '0;
            if (accept)
                err <= 1'b0;
            else if (drain_tmo)
                err <= 1'b1;
        end
    end

    always_comb begin
        next      = state;
        accept    = 1'b0;
        k_clr     = 1'b0;
        k_inc     = 1'b0;
        layer_inc = 1'b0;
        drain_tmo = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    next   = (cfg_layers == '0) ? FINISH : LOAD_W;
                end
            end
            LOAD_W: next = WAIT_W;
            WAIT_W: begin
                if (!w_busy) begin
                    k_clr = 1'b1;
                    next  = STREAM;
                end
            end
            STREAM: begin
                k_inc = 1'b1;
                if (last_read)
                    next = DRAIN;
            end
            DRAIN: begin
                if (&mac_valid_out) begin
                    next = CAPTURE;
                end else if (drain_cnt == DW'(DRAIN_TO - 1)) begin
                    drain_tmo = 1'b1;
                    next      = CAPTURE;
                end
            end
            CAPTURE: next = CLEAR;
            CLEAR: begin
                if (last_layer) begin
                    next = FINISH;
                end else begin
                    layer_inc = 1'b1;
                    next      = LOAD_W;
                end
            end
            FINISH:  next = IDLE;
            default: next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign w_load    = (state == LOAD_W);
    assign in_rd_en  = (state == STREAM);
    assign capture   = (state == CAPTURE);
    assign mac_valid = {N_MACS{mv_q}};
    assign mac_clear = {N_MACS{state == CLEAR}};

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Self-checking bench for layer_seq_ctrl: vector table plus address
// scoreboard, with hand sequences for latency, timeout and reset.
module tb_layer_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] cfg_layers = '0;
    logic [7:0] cfg_k = '0;
    logic       busy, done, err, w_load, in_rd_en, capture;
    logic [2:0] layer_idx;
    logic [7:0] w_base, in_addr;
    logic       w_busy = 1'b0;
    logic [3:0] mac_valid, mac_clear;
    logic [3:0] mac_valid_out = '0;

    layer_seq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_layers    (cfg_layers),
        .cfg_k         (cfg_k),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .layer_idx     (layer_idx),
        .w_load        (w_load),
        .w_base        (w_base),
        .w_busy        (w_busy),
        .in_rd_en      (in_rd_en),
        .in_addr       (in_addr),
        .mac_valid     (mac_valid),
        .mac_clear     (mac_clear),
        .mac_valid_out (mac_valid_out),
        .capture       (capture)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [7:0] q_addr[$];
    logic [7:0] q_wb[$];

    int n_cap = 0, n_clr = 0, n_done = 0, n_wl = 0, n_rd = 0;
    int last_rd = 0, last_cap = 0;
    bit err_at_cap = 0;
    bit prev_rd = 0, armed = 0, tmo_mode = 0, fast_w = 0;
    int mv_cnt = 0, wb_cnt = 0;

    typedef struct {
        int layers;
        int k;
        bit tmo;
        bit mid;
        int caps;
        int wl;
        int rd;
        bit exp_err;
        int gap;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor plus weight-interface and MAC-array responders.
    always @(negedge clk) begin
        if (rst) begin
            prev_rd = 0;
            armed = 0;
            mv_cnt = 0;
            wb_cnt = 0;
            w_busy = 1'b0;
            mac_valid_out = 4'h0;
        end else begin
            chk("mac_valid_align", int'(mac_valid), prev_rd ? 15 : 0);
            if (mac_clear != 4'h0) begin
                n_clr++;
                chk("clear_bits", int'(mac_clear), 15);
                chk("clear_vs_valid", int'(mac_valid), 0);
            end
            if (w_load) begin
                n_wl++;
                if (q_wb.size() == 0)
                    chk("unexpected_w_load", 1, 0);
                else
                    chk("w_base", int'(w_base), int'(q_wb.pop_front()));
                wb_cnt = 2;
                w_busy = fast_w ? 1'b0 : 1'b1;
            end else if (wb_cnt > 0) begin
                wb_cnt--;
                if (wb_cnt == 0)
                    w_busy = 1'b0;
            end
            if (in_rd_en) begin
                n_rd++;
                last_rd = cyc;
                if (q_addr.size() == 0)
                    chk("unexpected_rd", 1, 0);
                else
                    chk("in_addr", int'(in_addr), int'(q_addr.pop_front()));
            end
            if (capture) begin
                n_cap++;
                last_cap = cyc;
                err_at_cap = err;
                chk("capture_vs_valid", int'(mac_valid), 0);
                armed = 0;
                mv_cnt = 0;
            end
            if (done) begin
                n_done++;
                chk("done_with_busy", int'(busy), 1);
            end
            if (mac_valid != 4'h0) begin
                armed = 1;
                mv_cnt = 0;
            end else if (armed) begin
                mv_cnt++;
            end
            if (tmo_mode)
                mac_valid_out = 4'h7;
            else
                mac_valid_out = (armed && mv_cnt >= 2) ? 4'hF : 4'h0;
            prev_rd = in_rd_en;
        end
    end

    task automatic push_exp(input int layers, input int k);
        int kk;
        kk = (k == 0) ? 256 : k;
        for (int l = 0; l < layers; l++) begin
            q_wb.push_back(8'((l * 4) % 256));
            for (int j = 0; j < kk; j++)
                q_addr.push_back(8'((l * k + j) % 256));
        end
    endtask

    task automatic wait_done(input string nm, input int bound);
        bit seen;
        seen = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk(nm, int'(seen), 1);
        @(negedge clk);
        chk({nm, "_busy_low"}, int'(busy), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int c0, cl0, d0, w0, r0;
        bit seen;
        push_exp(v.layers, v.k);
        tmo_mode = v.tmo;
        c0 = n_cap; cl0 = n_clr; d0 = n_done; w0 = n_wl; r0 = n_rd;
        @(negedge clk);
        cfg_layers = 3'(v.layers);
        cfg_k = 8'(v.k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (v.mid) begin
            seen = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (in_rd_en) begin
                    seen = 1;
                    break;
                end
            end
            chk($sformatf("v%0d_mid_stream", idx), int'(seen), 1);
            cfg_layers = 3'd5;
            cfg_k = 8'd9;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done($sformatf("v%0d_done", idx), 3000);
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_captures", idx), n_cap - c0, v.caps);
        chk($sformatf("v%0d_clears", idx), n_clr - cl0, v.caps);
        chk($sformatf("v%0d_dones", idx), n_done - d0, 1);
        chk($sformatf("v%0d_w_loads", idx), n_wl - w0, v.wl);
        chk($sformatf("v%0d_reads", idx), n_rd - r0, v.rd);
        chk($sformatf("v%0d_gap", idx), last_cap - last_rd, v.gap);
        chk($sformatf("v%0d_err_at_cap", idx), int'(err_at_cap), int'(v.exp_err));
        chk($sformatf("v%0d_err", idx), int'(err), int'(v.exp_err));
        chk($sformatf("v%0d_sb_empty", idx), q_addr.size() + q_wb.size(), 0);
        tmo_mode = 0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctrl"}, int'({busy, done, err, w_load, in_rd_en, capture}), 0);
        chk({nm, "_mac"}, int'({mac_valid, mac_clear}), 0);
        chk({nm, "_layer_idx"}, int'(layer_idx), 0);
        chk({nm, "_in_addr"}, int'(in_addr), 0);
        chk({nm, "_w_base"}, int'(w_base), 0);
    endtask

    initial begin
        int d0, w0, r0;
        bit seen;

        vecs[0] = '{layers:1, k:4, tmo:0, mid:0, caps:1, wl:1, rd:4,   exp_err:0, gap:4};
        vecs[1] = '{layers:3, k:5, tmo:0, mid:0, caps:3, wl:3, rd:15,  exp_err:0, gap:4};
        vecs[2] = '{layers:1, k:0, tmo:0, mid:0, caps:1, wl:1, rd:256, exp_err:0, gap:4};
        vecs[3] = '{layers:2, k:6, tmo:0, mid:1, caps:2, wl:2, rd:12,  exp_err:0, gap:4};
        vecs[4] = '{layers:1, k:3, tmo:1, mid:0, caps:1, wl:1, rd:3,   exp_err:1, gap:33};

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("idle");

        for (int i = 0; i < 5; i++)
            run_vec(vecs[i], i);

        // Latency from start to w_load and first read; err clears on start.
        fast_w = 1;
        push_exp(1, 2);
        @(negedge clk);
        chk("err_sticky", int'(err), 1);
        cfg_layers = 3'd1;
        cfg_k = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lat_c1_busy", int'(busy), 1);
        chk("lat_c1_w_load", int'(w_load), 1);
        chk("lat_c1_err_cleared", int'(err), 0);
        @(negedge clk);
        chk("lat_c2_rd", int'(in_rd_en), 0);
        @(negedge clk);
        chk("lat_c3_rd", int'(in_rd_en), 1);
        wait_done("lat_done", 200);
        fast_w = 0;

        // Zero layers: straight to done, no weight load or reads.
        d0 = n_done; w0 = n_wl; r0 = n_rd;
        @(negedge clk);
        cfg_layers = 3'd0;
        cfg_k = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = done;
        if (!seen) begin
            @(negedge clk);
            seen = done;
        end
        chk("l0_done_within_2", int'(seen), 1);
        repeat (3) @(negedge clk);
        chk("l0_dones", n_done - d0, 1);
        chk("l0_w_loads", n_wl - w0, 0);
        chk("l0_reads", n_rd - r0, 0);
        chk("l0_busy_low", int'(busy), 0);

        // Reset during layer 1 streaming, after in_addr has wrapped.
        push_exp(2, 200);
        r0 = n_rd;
        @(negedge clk);
        cfg_layers = 3'd2;
        cfg_k = 8'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (n_rd - r0 >= 260) begin
                seen = 1;
                break;
            end
        end
        chk("rst_wrap_reached", int'(seen), 1);
        chk("rst_pre_layer1", int'(layer_idx), 1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        q_addr.delete();
        q_wb.delete();
        push_exp(1, 3);
        @(negedge clk);
        cfg_layers = 3'd1;
        cfg_k = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_layer_idx", int'(layer_idx), 0);
        chk("restart_w_load", int'(w_load), 1);
        wait_done("restart_done", 200);
        chk("restart_sb_empty", q_addr.size() + q_wb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
